// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush insertion
// and saturating stall/flush statistics counters.
module id_ex_hazard_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Freeze,
  input  logic                 Flush,
  input  logic                 CntClr,
  input  logic [5+ALUOP_W:0]   ID_Ctrl,
  input  logic                 ID_UsesRs,
  input  logic                 ID_UsesRt,
  input  logic [DATA_W-1:0]    ID_PC4,
  input  logic [DATA_W-1:0]    ID_ReadData1,
  input  logic [DATA_W-1:0]    ID_ReadData2,
  input  logic [DATA_W-1:0]    ID_SignExt,
  input  logic [RADDR_W-1:0]   ID_RegRs,
  input  logic [RADDR_W-1:0]   ID_RegRt,
  input  logic [RADDR_W-1:0]   ID_RegRd,
  output logic [5+ALUOP_W:0]   IDEX_Ctrl,
  output logic [DATA_W-1:0]    IDEX_PC4,
  output logic [DATA_W-1:0]    IDEX_ReadData1,
  output logic [DATA_W-1:0]    IDEX_ReadData2,
  output logic [DATA_W-1:0]    IDEX_SignExt,
  output logic [RADDR_W-1:0]   IDEX_RegRs,
  output logic [RADDR_W-1:0]   IDEX_RegRt,
  output logic [RADDR_W-1:0]   IDEX_WriteReg,
  output logic                 Stall,
  output logic                 PCWrite,
  output logic                 IFIDWrite,
  output logic [CNT_W-1:0]     StallCount,
  output logic [CNT_W-1:0]     FlushCount
);

  localparam int REGDST_BIT   = ALUOP_W;
  localparam int MEMWRITE_BIT = ALUOP_W + 2;
  localparam int MEMREAD_BIT  = ALUOP_W + 3;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic idexMemRead;
  logic idMemWrite;
  logic rsHit;
  logic rtHit;
  logic hazard;
  logic bubble;

  assign idexMemRead = IDEX_Ctrl[MEMREAD_BIT];
  assign idMemWrite  = ID_Ctrl[MEMWRITE_BIT];
  assign rsHit = ID_UsesRs & (ID_RegRs == IDEX_RegRt);
  // Store data from a load is forwarded in MEM, so it never needs a bubble.
  assign rtHit = ID_UsesRt & (ID_RegRt == IDEX_RegRt) & ~idMemWrite;
  assign hazard = idexMemRead & (IDEX_RegRt != '0) & (rsHit | rtHit);

  assign Stall     = hazard & ~Flush & ~Freeze;
  assign PCWrite   = ~Stall & ~Freeze;
  assign IFIDWrite = ~Stall & ~Freeze;
  assign bubble    = Flush | Stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      IDEX_Ctrl      <= '0;
      IDEX_PC4       <= '0;
      IDEX_ReadData1 <= '0;
      IDEX_ReadData2 <= '0;
      IDEX_SignExt   <= '0;
      IDEX_RegRs     <= '0;
      IDEX_RegRt     <= '0;
      IDEX_WriteReg  <= '0;
    end else if (!Freeze) begin
      IDEX_PC4       <= ID_PC4;
      IDEX_ReadData1 <= ID_ReadData1;
      IDEX_ReadData2 <= ID_ReadData2;
      IDEX_SignExt   <= ID_SignExt;
      IDEX_RegRs     <= ID_RegRs;
      IDEX_RegRt     <= ID_RegRt;
      if (bubble) begin
        IDEX_Ctrl     <= '0;
        IDEX_WriteReg <= '0;
      end else begin
        IDEX_Ctrl     <= ID_Ctrl;
        IDEX_WriteReg <= ID_Ctrl[REGDST_BIT] ? ID_RegRd : ID_RegRt;
      end
    end
  end

  // Index 0 counts stall cycles, index 1 counts applied flushes.
  logic [1:0]       cntInc;
  logic [CNT_W-1:0] cntVal [2];

  assign cntInc = {Flush, Stall};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : genCnt
      logic [CNT_W-1:0] cntReg;

      always_ff @(posedge clk) begin
        if (rst || CntClr) begin
          cntReg <= '0;
        end else if (!Freeze && cntInc[gi] && (cntReg != CNT_MAX)) begin
          cntReg <= cntReg + CNT_ONE;
        end
      end

      assign cntVal[gi] = cntReg;
    end
  endgenerate

  assign StallCount = cntVal[0];
  assign FlushCount = cntVal[1];

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Self-checking bench for id_ex_hazard_reg: directed test-plan scenarios followed by
// randomized traffic, all checked against a behavioural pipeline-register model.
module tb_id_ex_hazard_reg;

  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 4;
  localparam int CTRL_W  = 6 + ALUOP_W;
  localparam int MAXCNT  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, freeze, flush, cntClr;
  logic [CTRL_W-1:0]  idCtrl;
  logic               idUsesRs, idUsesRt;
  logic [DATA_W-1:0]  idPc4, idRd1, idRd2, idSext;
  logic [RADDR_W-1:0] idRs, idRt, idRd;
  logic [CTRL_W-1:0]  exCtrl;
  logic [DATA_W-1:0]  exPc4, exRd1, exRd2, exSext;
  logic [RADDR_W-1:0] exRs, exRt, exWr;
  logic               stall, pcWrite, ifidWrite;
  logic [CNT_W-1:0]   stallCount, flushCount;

  id_ex_hazard_reg #(
    .DATA_W(DATA_W), .RADDR_W(RADDR_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .Freeze(freeze), .Flush(flush), .CntClr(cntClr),
    .ID_Ctrl(idCtrl), .ID_UsesRs(idUsesRs), .ID_UsesRt(idUsesRt),
    .ID_PC4(idPc4), .ID_ReadData1(idRd1), .ID_ReadData2(idRd2), .ID_SignExt(idSext),
    .ID_RegRs(idRs), .ID_RegRt(idRt), .ID_RegRd(idRd),
    .IDEX_Ctrl(exCtrl), .IDEX_PC4(exPc4), .IDEX_ReadData1(exRd1),
    .IDEX_ReadData2(exRd2), .IDEX_SignExt(exSext), .IDEX_RegRs(exRs),
    .IDEX_RegRt(exRt), .IDEX_WriteReg(exWr), .Stall(stall), .PCWrite(pcWrite),
    .IFIDWrite(ifidWrite), .StallCount(stallCount), .FlushCount(flushCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: what the ID/EX stage holds, as plain values.
  logic [CTRL_W-1:0]  mCtrl;
  logic [DATA_W-1:0]  mPc4, mRd1, mRd2, mSext;
  logic [RADDR_W-1:0] mRs, mRt, mWr;
  int mStallCnt, mFlushCnt;
  logic lastStall, lastPcw;

  // Control bundle helpers {RegWrite,MemToReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp}
  localparam logic [CTRL_W-1:0] LW_CTRL  = {6'b111010, 4'h0};
  localparam logic [CTRL_W-1:0] ADD_CTRL = {6'b100001, 4'h2};
  localparam logic [CTRL_W-1:0] SW_CTRL  = {6'b000110, 4'h0};

  task automatic setInstr(input logic [CTRL_W-1:0] c, input logic ur, input logic ut,
                          input int rs, input int rt, input int rd);
    idCtrl = c; idUsesRs = ur; idUsesRt = ut;
    idRs = RADDR_W'(rs); idRt = RADDR_W'(rt); idRd = RADDR_W'(rd);
    idPc4 = $urandom; idRd1 = $urandom; idRd2 = $urandom; idSext = $urandom;
  endtask

  task automatic randInputs();
    idCtrl = CTRL_W'($urandom);
    idUsesRs = 1'($urandom); idUsesRt = 1'($urandom);
    idRs = RADDR_W'($urandom_range(0, 3));
    idRt = RADDR_W'($urandom_range(0, 3));
    idRd = RADDR_W'($urandom_range(0, 31));
    idPc4 = $urandom; idRd1 = $urandom; idRd2 = $urandom; idSext = $urandom;
  endtask

  // One clock: check combinational outputs mid-cycle, then registered outputs after the edge.
  task automatic cycle();
    logic hz, expStall, expPcw;
    logic [CTRL_W-1:0] nCtrl;
    logic [RADDR_W-1:0] nWr;
    @(negedge clk);
    hz = mCtrl[ALUOP_W+3] && (mRt != 0) &&
         ((idUsesRs && idRs == mRt) || (idUsesRt && idRt == mRt && !idCtrl[ALUOP_W+2]));
    expStall = hz && !flush && !freeze;
    expPcw = !expStall && !freeze;
    checkVal("Stall", 32'(stall), 32'(expStall));
    checkVal("PCWrite", 32'(pcWrite), 32'(expPcw));
    checkVal("IFIDWrite", 32'(ifidWrite), 32'(expPcw));
    lastStall = stall;
    lastPcw = pcWrite;
    nCtrl = (flush || expStall) ? '0 : idCtrl;
    nWr = (flush || expStall) ? '0 : (idCtrl[ALUOP_W] ? idRd : idRt);
    @(posedge clk);
    #1;
    if (rst) begin
      mCtrl = '0; mPc4 = '0; mRd1 = '0; mRd2 = '0; mSext = '0;
      mRs = '0; mRt = '0; mWr = '0;
    end else if (!freeze) begin
      mCtrl = nCtrl; mWr = nWr; mPc4 = idPc4; mRd1 = idRd1; mRd2 = idRd2;
      mSext = idSext; mRs = idRs; mRt = idRt;
    end
    if (rst || cntClr) begin
      mStallCnt = 0; mFlushCnt = 0;
    end else if (!freeze) begin
      if (expStall && mStallCnt < MAXCNT) mStallCnt++;
      if (flush && mFlushCnt < MAXCNT) mFlushCnt++;
    end
    checkVal("IDEX_Ctrl", 32'(exCtrl), 32'(mCtrl));
    checkVal("IDEX_PC4", exPc4, mPc4);
    checkVal("IDEX_ReadData1", exRd1, mRd1);
    checkVal("IDEX_ReadData2", exRd2, mRd2);
    checkVal("IDEX_SignExt", exSext, mSext);
    checkVal("IDEX_RegRs", 32'(exRs), 32'(mRs));
    checkVal("IDEX_RegRt", 32'(exRt), 32'(mRt));
    checkVal("IDEX_WriteReg", 32'(exWr), 32'(mWr));
    checkVal("StallCount", 32'(stallCount), 32'(mStallCnt));
    checkVal("FlushCount", 32'(flushCount), 32'(mFlushCnt));
  endtask

  initial begin
    logic [DATA_W-1:0] heldPc4;
    logic [CTRL_W-1:0] heldCtrl;
    int heldStall, heldFlush, txn;

    mCtrl = '0; mPc4 = '0; mRd1 = '0; mRd2 = '0; mSext = '0;
    mRs = '0; mRt = '0; mWr = '0; mStallCnt = 0; mFlushCnt = 0;
    rst = 1'b1; freeze = 1'b0; flush = 1'b0; cntClr = 1'b0;
    randInputs();

    // Reset with random inputs
    cycle(); randInputs(); cycle();
    rst = 1'b0;
    checkVal("rstCtrl", 32'(exCtrl), 32'd0);
    checkVal("rstPC4", exPc4, 32'd0);
    checkVal("rstStallCount", 32'(stallCount), 32'd0);
    checkVal("rstFlushCount", 32'(flushCount), 32'd0);
    $display("txn reset: IDEX_Ctrl=%0h StallCount=%0d", exCtrl, stallCount);

    // Load-use: lw $8 then add using $8
    setInstr(LW_CTRL, 1, 0, 9, 8, 0); cycle();
    setInstr(ADD_CTRL, 1, 1, 8, 10, 11); cycle();
    checkVal("ldUseStall", 32'(lastStall), 32'd1);
    checkVal("ldUsePCWrite", 32'(lastPcw), 32'd0);
    checkVal("ldUseBubble", 32'(exCtrl), 32'd0);
    checkVal("ldUseStallCount", 32'(stallCount), 32'd1);
    cycle();
    checkVal("ldUseReissueStall", 32'(lastStall), 32'd0);
    checkVal("ldUseReissueCtrl", 32'(exCtrl), 32'(ADD_CTRL));
    checkVal("ldUseWriteReg", 32'(exWr), 32'd11);
    $display("txn load-use: bubble then add, StallCount=%0d", stallCount);

    // Store data dependency only: no stall; address dependency: stall
    setInstr(LW_CTRL, 1, 0, 9, 8, 0); cycle();
    setInstr(SW_CTRL, 1, 1, 9, 8, 0); cycle();
    checkVal("swDataNoStall", 32'(lastStall), 32'd0);
    checkVal("swLoads", 32'(exCtrl), 32'(SW_CTRL));
    setInstr(LW_CTRL, 1, 0, 9, 8, 0); cycle();
    setInstr(SW_CTRL, 1, 1, 8, 8, 0); cycle();
    checkVal("swAddrStall", 32'(lastStall), 32'd1);
    $display("txn store: data-only no stall, address stall=%0b", lastStall);

    // $zero and unused operands
    setInstr(LW_CTRL, 1, 0, 9, 0, 0); cycle();
    setInstr(ADD_CTRL, 1, 1, 0, 0, 12); cycle();
    checkVal("zeroNoStall", 32'(lastStall), 32'd0);
    setInstr(LW_CTRL, 1, 0, 9, 8, 0); cycle();
    setInstr(ADD_CTRL, 1, 0, 9, 8, 12); cycle();
    checkVal("unusedRtNoStall", 32'(lastStall), 32'd0);
    $display("txn zero/unused: no stalls");

    // Flush beats hazard
    setInstr(LW_CTRL, 1, 0, 9, 8, 0); cycle();
    heldStall = int'(stallCount); heldFlush = int'(flushCount);
    setInstr(ADD_CTRL, 1, 1, 8, 10, 11); flush = 1'b1; cycle(); flush = 1'b0;
    checkVal("flushStall", 32'(lastStall), 32'd0);
    checkVal("flushPCWrite", 32'(lastPcw), 32'd1);
    checkVal("flushCtrl", 32'(exCtrl), 32'd0);
    checkVal("flushCountInc", 32'(flushCount), 32'(heldFlush + 1));
    checkVal("flushStallCountHeld", 32'(stallCount), 32'(heldStall));
    $display("txn flush+hazard: FlushCount=%0d StallCount=%0d", flushCount, stallCount);

    // Freeze holds everything for 3 cycles
    setInstr(ADD_CTRL, 1, 1, 3, 4, 5); cycle();
    heldPc4 = exPc4; heldCtrl = exCtrl; heldStall = int'(stallCount);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randInputs(); flush = 1'($urandom); cycle();
      checkVal("freezePC4", exPc4, heldPc4);
      checkVal("freezeCtrl", 32'(exCtrl), 32'(heldCtrl));
      checkVal("freezePCWrite", 32'(lastPcw), 32'd0);
      checkVal("freezeStallCount", 32'(stallCount), 32'(heldStall));
    end
    freeze = 1'b0; flush = 1'b0;
    $display("txn freeze: 3 cycles held");

    // Saturation: 20 load-use stalls with a 4-bit counter
    cntClr = 1'b1; setInstr(ADD_CTRL, 1, 1, 1, 2, 3); cycle(); cntClr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      setInstr(LW_CTRL, 1, 0, 9, 8, 0); cycle();
      setInstr(ADD_CTRL, 1, 1, 8, 10, 11); cycle();
    end
    checkVal("stallSaturate", 32'(stallCount), 32'd15);
    heldPc4 = exPc4;
    freeze = 1'b1; cntClr = 1'b1; randInputs(); cycle();
    freeze = 1'b0; cntClr = 1'b0;
    checkVal("clrDuringFreeze", 32'(stallCount), 32'd0);
    checkVal("clrFreezeHeld", exPc4, heldPc4);
    $display("txn saturate: StallCount cleared to %0d during freeze", stallCount);

    // Randomized traffic with occasional reset, freeze, flush and clear
    for (txn = 0; txn < 3000; txn++) begin
      randInputs();
      rst    = ($urandom_range(0, 99) < 2);
      freeze = ($urandom_range(0, 99) < 10);
      flush  = ($urandom_range(0, 99) < 12);
      cntClr = ($urandom_range(0, 99) < 2);
      cycle();
    end
    rst = 1'b0; freeze = 1'b0; flush = 1'b0; cntClr = 1'b0;
    $display("txn random: 3000 cycles, StallCount=%0d FlushCount=%0d", stallCount, flushCount);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
- ID/EX pipeline register of the 5-stage MIPS32 core, with load-use hazard detection and bubble/flush insertion.
- Captures decoded control, operands, immediate and register addresses each cycle. These registered Rs/Rt/WriteReg/control fields feed the EX-stage forwarding unit and the EX/MEM register.
- Drives the PC and IF/ID write enables. Keeps saturating stall/flush statistics counters.

Parameters:
DATA_W, 32, operand/immediate/PC width
RADDR_W, 5, register address width
ALUOP_W, 4, ALU operation code width
CNT_W, 16, statistics counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
Freeze  in  1  external whole-pipeline hold (memory wait)
Flush  in  1  branch/jump taken in EX; kill instruction entering ID/EX
CntClr  in  1  synchronous clear of statistics counters
ID_Ctrl  in  6+ALUOP_W  {RegWrite,MemToReg,MemRead,MemWrite,ALUSrc,RegDst,ALUOp}
ID_UsesRs  in  1  ID instruction reads Rs
ID_UsesRt  in  1  ID instruction reads Rt
ID_PC4  in  DATA_W  PC+4 of ID instruction
ID_ReadData1  in  DATA_W  register file Rs data
ID_ReadData2  in  DATA_W  register file Rt data
ID_SignExt  in  DATA_W  sign-extended immediate
ID_RegRs  in  RADDR_W  Rs field
ID_RegRt  in  RADDR_W  Rt field
ID_RegRd  in  RADDR_W  Rd field
IDEX_Ctrl  out  6+ALUOP_W  registered control bundle, same packing
IDEX_PC4, IDEX_ReadData1, IDEX_ReadData2, IDEX_SignExt  out  DATA_W each  registered copies
IDEX_RegRs, IDEX_RegRt  out  RADDR_W each  registered source addresses (to forwarding unit)
IDEX_WriteReg  out  RADDR_W  registered destination: RegDst ? Rd : Rt
Stall  out  1  load-use bubble being inserted this cycle (combinational)
PCWrite  out  1  PC enable (combinational)
IFIDWrite  out  1  IF/ID enable (combinational)
StallCount  out  CNT_W  cycles with Stall=1
FlushCount  out  CNT_W  cycles with a Flush applied

Behaviour:
- Reset: every registered output, including counters, is 0. Control zero means a NOP bubble.
- Hazard (combinational) = IDEX_MemRead & (IDEX_RegRt != 0) & (rsHit | rtHit).
  - rsHit = ID_UsesRs & (ID_RegRs == IDEX_RegRt).
  - rtHit = ID_UsesRt & (ID_RegRt == IDEX_RegRt) & ~ID_MemWrite.
  - A load followed by a store whose only dependency is store data does not stall; the MEM-stage forward path covers it.
- Stall = Hazard & ~Flush & ~Freeze.
- PCWrite = IFIDWrite = ~Stall & ~Freeze. Both stay 1 during Flush so the branch target loads.
- Register update priority per edge: rst > Freeze > Flush > Stall > normal load.
  - Freeze: all ID/EX contents held; counters hold.
  - Flush: IDEX_Ctrl <= 0, IDEX_WriteReg <= 0; data/address fields load normally.
  - Stall: same as Flush (bubble); IF/ID and PC hold, so the dependent instruction re-presents next cycle.
  - Normal: all fields load; IDEX_WriteReg <= ID_RegDst ? ID_RegRd : ID_RegRt.
- Latency: one cycle from ID inputs to IDEX outputs. A load-use pair costs exactly one bubble cycle; the hazard clears automatically because the bubble has MemRead=0.
- Counters, when not frozen:
  - StallCount += 1 when Stall=1.
  - FlushCount += 1 when Flush=1.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - CntClr zeroes both and takes precedence over increment, even during Freeze. rst also zeroes them.
- Flush and Hazard in the same cycle: Flush wins, Stall=0, one bubble only, and the flush is counted.
- rst asserted mid-stall: next cycle all outputs are 0 and the stall is abandoned.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all IDEX_* = 0, StallCount=FlushCount=0, PCWrite=IFIDWrite=1.
- Load-use: lw $8 in ID/EX (MemRead=1, RegRt=8); ID add with Rs=8, UsesRs=1 -> Stall=1, PCWrite=0, next IDEX_Ctrl=0, StallCount=1. Following cycle add loads with Ctrl intact and Stall=0.
- Store data: lw $8 in ID/EX; ID sw with Rt=8, Rs=9, MemWrite=1 -> Stall=0, sw loads. Same sw with Rs=8 -> Stall=1.
- $zero and unused operands: lw with RegRt=0 and ID Rs=0 -> no stall; ID_UsesRt=0 with Rt=8 -> no stall.
- Flush vs. hazard: load-use condition with Flush=1 -> Stall=0, PCWrite=1, IDEX_Ctrl=0, FlushCount+1, StallCount unchanged.
- Freeze and saturation: Freeze=1 for 3 cycles -> IDEX_* unchanged, PCWrite=0, counters held. With CNT_W=4 and 20 stall cycles -> StallCount=15. CntClr during Freeze -> StallCount=0.
